shift_seq_ctrl: RTL
===================

# shift_seq_ctrl

Transaction sequencer that sits directly upstream of the 4-bit universal shift register (`shiftReg`) and drives its mode selects, serial inputs, output enables and shared bidirectional bus. Each accepted request parallel-loads a word, shifts it left or right by a requested amount with a chosen fill bit, then reads the result back over the same bus. The result is returned as `rd_data` with a `rd_valid` pulse. This block is the only agent besides `shiftReg` that touches `bidir`, and it guarantees no bus contention.

## Interface
- `WIDTH`, default 4: register/bus width; must match `shiftReg`.
- `SHW`, default 3: shift-amount width; must satisfy 2^SHW > WIDTH.

Ports:
- `clk` in 1: single clock, rising-edge.
- `mr` in 1: reset, asynchronous, active-high.
- `in_data` in WIDTH: word to load.
- `in_shamt` in SHW: shift count; values above WIDTH are clamped to WIDTH.
- `in_dir` in 1: 0 = right (`ds0` enters `q[0]`, `q[i]<=q[i-1]`); 1 = left (`ds3` enters `q[WIDTH-1]`, `q[i]<=q[i+1]`).
- `in_fill` in 1: serial fill bit.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted on an edge where `in_valid&in_ready` is 1.
- `s0`, `s1` out 1 each: `shiftReg` mode. 00 = hold, 10 (`s0`=1) = shift right, 01 = shift left, 11 = parallel load.
- `ds0`, `ds3` out 1 each: serial inputs to `shiftReg`.
- `oe1`, `oe2` out 1 each: active-low `shiftReg` output enables. Both are always driven equal.
- `bus_out` out WIDTH: data this block drives onto `bidir`.
- `bus_oe` out 1: tristate enable for `bus_out`.
- `bus_in` in WIDTH: `bidir` sampled.
- `rd_data` out WIDTH: result word.
- `rd_valid` out 1: one-cycle result strobe.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, LOAD, SHIFT, TURN, READ.
- **Outputs:** all outputs are registered, decoded from the state and the latched request.
- **IDLE**
  - `in_ready`=1, `s1s0`=00, `oe1`=`oe2`=1, `bus_oe`=0.
  - On accept: latch data, dir and fill; latch `k = min(in_shamt, WIDTH)`; go to LOAD.
- **LOAD** (1 cycle)
  - `s0`=`s1`=1, `oe1`=`oe2`=1, `bus_oe`=1, `bus_out`=latched data.
  - Next state is SHIFT if k>0, else TURN.
- **SHIFT** (exactly k cycles)
  - Mode is 10 for dir 0 or 01 for dir 1; `bus_oe`=0, `oe`=1.
  - `ds0` = fill when dir=0, `ds3` = fill when dir=1; the unused serial input is 0.
  - A down-counter loaded with k is decremented each cycle; exit to TURN when it reaches 1.
- **TURN** (1 cycle)
  - Mode 00, `bus_oe`=0, `oe`=1. This is the bus turnaround cycle.
- **READ** (1 cycle)
  - Mode 00, `oe1`=`oe2`=0, `bus_oe`=0.
  - `bus_in` is captured into `rd_data` on the closing edge; go to IDLE with `rd_valid`=1 for one cycle.
- **Expected result:**
  - dir 0: `rd_data = (data << k) | fill-bits in k LSBs`.
  - dir 1: `rd_data = (data >> k) | fill-bits in k MSBs`.
  - k = WIDTH gives an all-fill word.
- **Invariant:** `bus_oe`=1 and `oe1`=`oe2`=0 never occur in the same cycle. At least one cycle with both disabled separates them.
- **Reset:**
  - `mr`=1 forces IDLE immediately and drops any transaction; no `rd_valid` is produced.
  - Outputs under reset: `s0`=`s1`=0, `ds0`=`ds3`=0, `oe1`=`oe2`=1, `bus_oe`=0, `bus_out`=0, `rd_data`=0, `rd_valid`=0, `busy`=0, `in_ready`=0.
  - `in_ready` rises on the first edge after `mr` falls.

## Timing
- Cycles are counted from the accept edge (cycle 0):
  - LOAD: cycle 1.
  - SHIFT: cycles 2..k+1.
  - TURN: cycle k+2.
  - READ: cycle k+3.
  - `rd_valid`=1 and `in_ready`=1: cycle k+4.
- Latency from accept to `rd_valid` is k+4 cycles: minimum 4, maximum WIDTH+4.
- Back-to-back: a new request can be accepted on the edge that closes cycle k+4, so throughput is one word per k+4 cycles.
- `in_data`, `in_shamt`, `in_dir` and `in_fill` are sampled only at the accept edge. Later changes are ignored.
- `in_valid` asserted during `busy` is held off (`in_ready`=0); the request is neither lost nor accepted early.
- The `shiftReg` parallel load occurs on the edge closing LOAD. Each shift occurs on the edge closing its SHIFT cycle.

## Test plan
All scenarios use WIDTH=4 with a real `shiftReg` instance on the shared `bidir` net.
1. **Right shift:** data 1011, k=1, dir 0, fill 0 -> `rd_data`=0110, `rd_valid` 5 cycles after accept.
2. **Left shift:** data 1011, k=2, dir 1, fill 1 -> `rd_data`=1110, latency 6; `ds3`=1 and `ds0`=0 during both SHIFT cycles.
3. **Zero shift:** data 1011, k=0 -> `rd_data`=1011, latency 4, no SHIFT cycle. **Clamp:** k=7, dir 0, fill 1 -> `rd_data`=1111, latency 8.
4. **Back-to-back:** two requests with `in_valid` held high -> second accepted in the `rd_valid` cycle of the first; both results correct. Assert bus non-contention every cycle, and assert `bidir` is never X during READ.
5. **Reset mid-operation:** assert `mr` during SHIFT cycle 2 of a k=4 request -> outputs take reset values immediately, no `rd_valid`. A fresh request after release completes normally.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a 4-bit universal shift register: parallel-load a word, shift it
// k places with a fill bit, then read it back over the shared bidirectional bus.
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             mr,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
    input  logic             in_fill,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             s0,
    output logic             s1,
    output logic             ds0,
    output logic             ds3,
    output logic             oe1,
    output logic             oe2,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TURN, READ} state_t;

    state_t           state, state_nxt;
    logic [SHW-1:0]   cnt;
    logic             dir_q, fill_q;
    logic             accept;
    logic             s0_n, s1_n, ds0_n, ds3_n, oe_n, bus_oe_n;
    logic [WIDTH-1:0] bus_out_n;

    function automatic logic [SHW-1:0] clamp_shamt(input logic [SHW-1:0] s);
        return (s > SHW'(WIDTH)) ? SHW'(WIDTH) : s;
    endfunction

    assign accept = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = (cnt != '0) ? SHIFT : TURN;
            SHIFT:   if (cnt == SHW'(1)) state_nxt = TURN;
            TURN:    state_nxt = READ;
            READ:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they are registered yet aligned with it.
    // The word driven in LOAD comes straight from in_data because it is latched on the same edge.
    always_comb begin
        s0_n      = 1'b0;
        s1_n      = 1'b0;
        ds0_n     = 1'b0;
        ds3_n     = 1'b0;
        oe_n      = 1'b1;
        bus_oe_n  = 1'b0;
        bus_out_n = '0;
        case (state_nxt)
            LOAD: begin
                s0_n      = 1'b1;
                s1_n      = 1'b1;
                bus_oe_n  = 1'b1;
                bus_out_n = in_data;
            end
            SHIFT: begin
                s0_n  = ~dir_q;
                s1_n  = dir_q;
                ds0_n = ~dir_q & fill_q;
                ds3_n = dir_q & fill_q;
            end
            READ:    oe_n = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            state    <= IDLE;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            s0       <= 1'b0;
            s1       <= 1'b0;
            ds0      <= 1'b0;
            ds3      <= 1'b0;
            oe1      <= 1'b1;
            oe2      <= 1'b1;
            bus_oe   <= 1'b0;
            bus_out  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == IDLE);
            busy     <= (state_nxt != IDLE);
            s0       <= s0_n;
            s1       <= s1_n;
            ds0      <= ds0_n;
            ds3      <= ds3_n;
            oe1      <= oe_n;
            oe2      <= oe_n;
            bus_oe   <= bus_oe_n;
            bus_out  <= bus_out_n;
            rd_valid <= (state == READ);
            if (state == READ) rd_data <= bus_in;
            if (accept) cnt <= clamp_shamt(in_shamt);
            else if (state == SHIFT) cnt <= cnt - SHW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dir_q  <= in_dir;
            fill_q <= in_fill;
        end
    end

endmodule
